// File: rtl/bus_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// bus_xfer_ctrl
//   Transfer sequencer for an 8x16 register bank that shares a tri-state read
//   bus. Executes MOV (copy src->dst), SWP (exchange src/dst) and LDI (load
//   immediate into dst). Produces the bank controls (rsel/tr/wrr), the write
//   data word, and samples the bus only while the bank is driving it.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_start      request, sampled only in IDLE
//   i_op         00=MOV 01=SWP 10=LDI 11=illegal
//   i_src/i_dst  source / destination register select
//   i_imm        immediate for LDI
//   i_bus        shared bus, valid only while o_tr=1
//   o_wdata      write data to the bank
//   o_rsel       register select
//   o_tr         bank output enable (read onto bus)
//   o_wrr        bank write enable
//   o_busy       high in every state except IDLE
//   o_done       one-cycle completion pulse
//   o_err        set with done for op=11, cleared on next accepted start
//   o_xfer_cnt   completed legal operations, wraps FFFF->0000
//
//   state | meaning
//   IDLE  | waiting for start
//   RDA   | bank drives reg[src] onto bus, captured into T0
//   RDB   | bank drives reg[dst] onto bus, captured into T1 (SWP only)
//   WRA   | write T1 into reg[src] (SWP only)
//   WRB   | write T0 (or immediate for LDI) into reg[dst]
//   DONE  | completion pulse, then back to IDLE
// ----------------------------------------------------------------------------
module bus_xfer_ctrl #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [AW-1:0]    i_src,
    input  logic [AW-1:0]    i_dst,
    input  logic [WIDTH-1:0] i_imm,
    input  logic [WIDTH-1:0] i_bus,
    output logic [WIDTH-1:0] o_wdata,
    output logic [AW-1:0]    o_rsel,
    output logic             o_tr,
    output logic             o_wrr,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [15:0]      o_xfer_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_WRA  = 3'd3,
        S_WRB  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_SWP = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [AW-1:0]      r_src;
    logic [AW-1:0]      r_dst;
    logic [WIDTH-1:0]   r_t0;
    logic [WIDTH-1:0]   r_wdata;
    logic [AW-1:0]      r_rsel;
    logic               r_tr;
    logic               r_wrr;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [15:0]        r_xfer_cnt;

    // Outputs are registered alongside the state: each branch loads the
    // values that belong to the state being entered. The write data for the
    // next WR state is loaded straight from the bus/immediate on the same
    // edge, so a separate T1 / latched-immediate register is not needed;
    // T0 is kept because SWP writes it two cycles after it was read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_t0       <= '0;
            r_wdata    <= '0;
            r_rsel     <= '0;
            r_tr       <= 1'b0;
            r_wrr      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            r_wdata <= '0;
            r_rsel  <= '0;
            r_tr    <= 1'b0;
            r_wrr   <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op   <= i_op;
                        r_src  <= i_src;
                        r_dst  <= i_dst;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        case (i_op)
                            OP_MOV, OP_SWP: begin
                                r_state <= S_RDA;
                                r_rsel  <= i_src;
                                r_tr    <= 1'b1;
                            end
                            OP_LDI: begin
                                r_state <= S_WRB;
                                r_rsel  <= i_dst;
                                r_wrr   <= 1'b1;
                                r_wdata <= i_imm;
                            end
                            default: begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                            end
                        endcase
                    end
                end

                S_RDA: begin
                    r_t0 <= i_bus;
                    if (r_op == OP_SWP) begin
                        r_state <= S_RDB;
                        r_rsel  <= r_dst;
                        r_tr    <= 1'b1;
                    end else begin
                        r_state <= S_WRB;
                        r_rsel  <= r_dst;
                        r_wrr   <= 1'b1;
                        r_wdata <= i_bus;
                    end
                end

                S_RDB: begin
                    r_state <= S_WRA;
                    r_rsel  <= r_src;
                    r_wrr   <= 1'b1;
                    r_wdata <= i_bus;
                end

                S_WRA: begin
                    r_state <= S_WRB;
                    r_rsel  <= r_dst;
                    r_wrr   <= 1'b1;
                    r_wdata <= r_t0;
                end

                S_WRB: begin
                    r_state    <= S_DONE;
                    r_done     <= 1'b1;
                    r_xfer_cnt <= r_xfer_cnt + 16'd1;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_wdata    = r_wdata;
    assign o_rsel     = r_rsel;
    assign o_tr       = r_tr;
    assign o_wrr      = r_wrr;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
module tb_bus_xfer_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic [2:0]  i_src = 3'd0;
    logic [2:0]  i_dst = 3'd0;
    logic [15:0] i_imm = 16'h0;
    logic [15:0] w_bus;
    logic [15:0] o_wdata;
    logic [2:0]  o_rsel;
    logic        o_tr;
    logic        o_wrr;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [15:0] o_xfer_cnt;

    bus_xfer_ctrl #(.WIDTH(16), .AW(3)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_src      (i_src),
        .i_dst      (i_dst),
        .i_imm      (i_imm),
        .i_bus      (w_bus),
        .o_wdata    (o_wdata),
        .o_rsel     (o_rsel),
        .o_tr       (o_tr),
        .o_wrr      (o_wrr),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_xfer_cnt (o_xfer_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Register bank environment: drives the bus when enabled, writes on wrr.
    logic [15:0] bank [0:7] = '{default: 16'h0000};
    always_comb w_bus = o_tr ? bank[o_rsel] : 16'hDEAD;
    always @(posedge i_clk) if (o_wrr) bank[o_rsel] <= o_wdata;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int overlap = 0;

    typedef struct packed { logic [2:0] rsel; logic [15:0] data; } wr_t;
    typedef struct { logic err; logic [15:0] cnt; int acc; int lat; } done_t;

    logic [2:0] q_rd [$];
    wr_t        q_wr [$];
    done_t      q_done [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a read, write or done.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_tr && o_wrr) overlap++;
            if (o_tr) begin
                if (q_rd.size() == 0) chk("unexpected_read", {29'd0, o_rsel}, 32'hFFFF_FFFF);
                else chk("read_rsel", {29'd0, o_rsel}, {29'd0, q_rd.pop_front()});
            end
            if (o_wrr) begin
                if (q_wr.size() == 0) chk("unexpected_write", {13'd0, o_rsel, o_wdata}, 32'hFFFF_FFFF);
                else begin
                    wr_t w;
                    w = q_wr.pop_front();
                    chk("write_rsel", {29'd0, o_rsel}, {29'd0, w.rsel});
                    chk("write_data", {16'd0, o_wdata}, {16'd0, w.data});
                end
            end
            if (o_done) begin
                if (q_done.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    done_t d;
                    d = q_done.pop_front();
                    chk("done_err", {31'd0, o_err}, {31'd0, d.err});
                    chk("done_cnt", {16'd0, o_xfer_cnt}, {16'd0, d.cnt});
                    chk("done_latency", cyc - d.acc, d.lat);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (o_busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue one request; expected done is queued before start is driven.
    task automatic go(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                      input logic [15:0] imm, input logic want_done, input logic err,
                      input logic [15:0] cnt, input int lat);
        done_t e;
        wait_idle();
        if (want_done) begin
            e.err = err; e.cnt = cnt; e.acc = cyc; e.lat = lat;
            q_done.push_back(e);
        end
        i_op = op; i_src = s; i_dst = d; i_imm = imm; i_start = 1'b1;
        @(negedge i_clk);
        // Scramble inputs after acceptance: the DUT must use latched values.
        i_start = 1'b0; i_op = 2'b11; i_src = ~s; i_dst = ~d; i_imm = ~imm;
    endtask

    function automatic wr_t mkw(input logic [2:0] r, input logic [15:0] dta);
        wr_t w;
        w.rsel = r; w.data = dta;
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge i_clk);
        chk("rst_busy",  {31'd0, o_busy}, 32'd0);
        chk("rst_done",  {31'd0, o_done}, 32'd0);
        chk("rst_tr",    {31'd0, o_tr},   32'd0);
        chk("rst_wrr",   {31'd0, o_wrr},  32'd0);
        chk("rst_err",   {31'd0, o_err},  32'd0);
        chk("rst_rsel",  {29'd0, o_rsel}, 32'd0);
        chk("rst_wdata", {16'd0, o_wdata}, 32'd0);
        chk("rst_cnt",   {16'd0, o_xfer_cnt}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // LDI R3=A5C3, R1=1234
        q_wr.push_back(mkw(3'd3, 16'hA5C3));
        go(2'b10, 3'd0, 3'd3, 16'hA5C3, 1'b1, 1'b0, 16'd1, 2);
        q_wr.push_back(mkw(3'd1, 16'h1234));
        go(2'b10, 3'd0, 3'd1, 16'h1234, 1'b1, 1'b0, 16'd2, 2);
        // MOV R1->R6
        q_rd.push_back(3'd1);
        q_wr.push_back(mkw(3'd6, 16'h1234));
        go(2'b00, 3'd1, 3'd6, 16'h0, 1'b1, 1'b0, 16'd3, 3);
        // R2=BEEF, R5=0F0F, SWP R2,R5
        q_wr.push_back(mkw(3'd2, 16'hBEEF));
        go(2'b10, 3'd0, 3'd2, 16'hBEEF, 1'b1, 1'b0, 16'd4, 2);
        q_wr.push_back(mkw(3'd5, 16'h0F0F));
        go(2'b10, 3'd0, 3'd5, 16'h0F0F, 1'b1, 1'b0, 16'd5, 2);
        q_rd.push_back(3'd2); q_rd.push_back(3'd5);
        q_wr.push_back(mkw(3'd2, 16'h0F0F)); q_wr.push_back(mkw(3'd5, 16'hBEEF));
        go(2'b01, 3'd2, 3'd5, 16'h0, 1'b1, 1'b0, 16'd6, 5);
        // Illegal op: err with done, no bus activity, count unchanged
        go(2'b11, 3'd1, 3'd2, 16'h0, 1'b1, 1'b1, 16'd6, 1);
        wait_idle();
        chk("err_held_in_idle", {31'd0, o_err}, 32'd1);
        q_wr.push_back(mkw(3'd7, 16'h0055));
        go(2'b10, 3'd0, 3'd7, 16'h0055, 1'b1, 1'b0, 16'd7, 2);
        // src==dst cases
        q_rd.push_back(3'd4);
        q_wr.push_back(mkw(3'd4, 16'h0000));
        go(2'b00, 3'd4, 3'd4, 16'h0, 1'b1, 1'b0, 16'd8, 3);
        q_rd.push_back(3'd3); q_rd.push_back(3'd3);
        q_wr.push_back(mkw(3'd3, 16'hA5C3)); q_wr.push_back(mkw(3'd3, 16'hA5C3));
        go(2'b01, 3'd3, 3'd3, 16'h0, 1'b1, 1'b0, 16'd9, 5);
        // MOV R6->R0 with start pulsed while busy and in DONE: no extra op
        q_rd.push_back(3'd6);
        q_wr.push_back(mkw(3'd0, 16'h1234));
        go(2'b00, 3'd6, 3'd0, 16'h0, 1'b1, 1'b0, 16'd10, 3);
        i_start = 1'b1; i_op = 2'b10; i_dst = 3'd1; i_imm = 16'hBAD0;
        @(negedge i_clk); i_start = 1'b0;
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("no_queued_op_busy", {31'd0, o_busy}, 32'd0);
        // Counter wrap
        wait_idle();
        force dut.r_xfer_cnt = 16'hFFFF;
        @(negedge i_clk);
        release dut.r_xfer_cnt;
        chk("cnt_preload", {16'd0, o_xfer_cnt}, 32'h0000_FFFF);
        q_rd.push_back(3'd1);
        q_wr.push_back(mkw(3'd7, 16'h1234));
        go(2'b00, 3'd1, 3'd7, 16'h0, 1'b1, 1'b0, 16'h0000, 3);
        // Reset in WRA of SWP R6,R2
        q_rd.push_back(3'd6); q_rd.push_back(3'd2);
        go(2'b01, 3'd6, 3'd2, 16'h0, 1'b0, 1'b0, 16'd0, 0);
        @(posedge i_clk); @(posedge i_clk); #1;
        chk("wra_wrr_before_rst", {31'd0, o_wrr}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_wrr",  {31'd0, o_wrr}, 32'd0);
        chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_mid_cnt",  {16'd0, o_xfer_cnt}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_src_R6", {16'd0, bank[6]}, 32'h1234);
        chk("rst_dst_R2", {16'd0, bank[2]}, 32'h0F0F);
        q_wr.push_back(mkw(3'd0, 16'h7777));
        go(2'b10, 3'd0, 3'd0, 16'h7777, 1'b1, 1'b0, 16'd1, 2);
        wait_idle();
        repeat (3) @(negedge i_clk);

        chk("q_rd_empty",   q_rd.size(),   32'd0);
        chk("q_wr_empty",   q_wr.size(),   32'd0);
        chk("q_done_empty", q_done.size(), 32'd0);
        chk("tr_wrr_overlap", overlap, 32'd0);
        chk("R0", {16'd0, bank[0]}, 32'h7777);
        chk("R1", {16'd0, bank[1]}, 32'h1234);
        chk("R2", {16'd0, bank[2]}, 32'h0F0F);
        chk("R3", {16'd0, bank[3]}, 32'hA5C3);
        chk("R4", {16'd0, bank[4]}, 32'h0000);
        chk("R5", {16'd0, bank[5]}, 32'hBEEF);
        chk("R6", {16'd0, bank[6]}, 32'h1234);
        chk("R7", {16'd0, bank[7]}, 32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
